// File: rtl/branch_resolve_unit_pkg.sv
// Shared front-end package for the branch predictor and the branch resolve unit.
// Holds the default table geometry, the counter reset value, the resolve FSM
// state encoding and the PC index/tag slicing helpers. The predictor and the
// resolve unit both use these helpers, so they always agree on which entry a
// PC maps to.
package branch_resolve_unit_pkg;

  localparam int DEF_IDX_W = 6;
  localparam int DEF_TAG_W = 8;

  // Every entry starts out weakly not taken.
  localparam logic [1:0] CNT_RESET = 2'b01;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } bru_state_e;

  // Instructions are word aligned, so the index starts at bit 2. The caller
  // size-casts the result down to its index width.
  function automatic logic [31:0] pc_index(input logic [31:0] pc);
    return pc >> 2;
  endfunction

  // The tag sits directly above the index bits; the caller size-casts it.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (2 + idx_w);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle between the pipeline and the branch resolve unit.
// master: pipeline side (drives the lookup PCs and the resolved ex_* fields,
//         receives predictions, flush/redirect and performance counters).
// slave:  branch resolve unit side.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      lk_pc_1;
  logic [31:0]      lk_pc_2;
  logic             lk_taken_1;
  logic             lk_taken_2;
  logic [31:0]      lk_target_1;
  logic [31:0]      lk_target_2;

  logic             ex_valid;
  logic             ex_is_branch;
  logic [31:0]      ex_pc;
  logic             ex_taken;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;

  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output lk_pc_1, lk_pc_2,
    input  lk_taken_1, lk_taken_2, lk_target_1, lk_target_2,
    output ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  flush, redirect_valid, redirect_pc, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  lk_pc_1, lk_pc_2,
    output lk_taken_1, lk_taken_2, lk_target_1, lk_target_2,
    input  ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output flush, redirect_valid, redirect_pc, branch_cnt, mispredict_cnt
  );

endinterface

// File: rtl/branch_pht_btb.sv
// Pattern history table plus branch target buffer.
// Two independent combinational read ports (one per fetch slot) and one
// synchronous write port used for training.
//   clk, rst               clock, synchronous active-high reset
//   rd_pc_*                lookup PC per fetch slot
//   rd_taken_*/rd_target_* prediction per fetch slot
//   wr_en                  train the entry selected by wr_pc
//   wr_pc/wr_taken/wr_target resolved outcome to train with
module branch_pht_btb
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rd_pc_1,
  input  logic [31:0] rd_pc_2,
  output logic        rd_taken_1,
  output logic        rd_taken_2,
  output logic [31:0] rd_target_1,
  output logic [31:0] rd_target_2,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic        wr_taken,
  input  logic [31:0] wr_target
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [1:0]       cnt_q    [DEPTH];

  logic [IDX_W-1:0] idx_1, idx_2, wr_idx;
  logic [TAG_W-1:0] tag_1, tag_2, wr_tag;
  logic             hit_1, hit_2;

  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  assign idx_1  = IDX_W'(pc_index(rd_pc_1));
  assign idx_2  = IDX_W'(pc_index(rd_pc_2));
  assign wr_idx = IDX_W'(pc_index(wr_pc));
  assign tag_1  = TAG_W'(pc_tag(rd_pc_1, IDX_W));
  assign tag_2  = TAG_W'(pc_tag(rd_pc_2, IDX_W));
  assign wr_tag = TAG_W'(pc_tag(wr_pc, IDX_W));

  // Reads see the array contents before this cycle's write lands; there is
  // deliberately no write-to-read bypass.
  assign hit_1       = valid_q[idx_1] && (tag_q[idx_1] == tag_1);
  assign hit_2       = valid_q[idx_2] && (tag_q[idx_2] == tag_2);
  assign rd_taken_1  = hit_1 && cnt_q[idx_1][1];
  assign rd_taken_2  = hit_2 && cnt_q[idx_2][1];
  assign rd_target_1 = hit_1 ? target_q[idx_1] : rd_pc_1 + 32'd4;
  assign rd_target_2 = hit_2 ? target_q[idx_2] : rd_pc_2 + 32'd4;

  // The counter is trained from whatever value the slot holds, even when a
  // taken branch with a different tag takes the slot over. Only taken
  // branches allocate or refresh the BTB fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RESET;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= cnt_update(cnt_q[wr_idx], wr_taken);
      if (wr_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: back-end half of the branch predictor.
// Checks resolved branches against the prediction carried down the pipe,
// raises a one-cycle flush/redirect on a mispredict, trains the PHT/BTB and
// counts resolved branches and mispredicts.
//   clk, rst  clock, synchronous active-high reset
//   bus       slave side of branch_resolve_unit_if (lookup ports, ex_*
//             resolve inputs, flush/redirect outputs, perf counters)
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_unit_if.slave bus
);

  bru_state_e       state_q;
  logic             flush_q;
  logic             redirect_valid_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_q;
  logic             resolve;
  logic             mispredict;

  // While REDIRECT is active the ex_* inputs belong to the wrong path, so
  // they neither train the tables nor count.
  assign resolve    = bus.ex_valid && bus.ex_is_branch && (state_q == IDLE);
  assign mispredict = (bus.ex_pred_taken != bus.ex_taken) ||
                      (bus.ex_taken && (bus.ex_pred_target != bus.ex_target));

  branch_pht_btb #(
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_pht_btb (
    .clk        (clk),
    .rst        (rst),
    .rd_pc_1    (bus.lk_pc_1),
    .rd_pc_2    (bus.lk_pc_2),
    .rd_taken_1 (bus.lk_taken_1),
    .rd_taken_2 (bus.lk_taken_2),
    .rd_target_1(bus.lk_target_1),
    .rd_target_2(bus.lk_target_2),
    .wr_en      (resolve),
    .wr_pc      (bus.ex_pc),
    .wr_taken   (bus.ex_taken),
    .wr_target  (bus.ex_target)
  );

  // flush/redirect_valid pulse for the single REDIRECT cycle; redirect_pc
  // keeps the last corrected address until the next mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (resolve) begin
            branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict) begin
              mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
              state_q          <= REDIRECT;
              flush_q          <= 1'b1;
              redirect_valid_q <= 1'b1;
              redirect_pc_q    <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
            end
          end
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit. Each task drives one scenario
// and checks results inline against hand-computed values.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_branch;
  int   exp_mis;

  localparam logic [31:0] PC_A = 32'h1c000010;
  localparam logic [31:0] PC_B = 32'h1c000040;
  localparam logic [31:0] PC_C = 32'h1c000080;
  localparam logic [31:0] PC_D = 32'h1c0000c0;
  localparam logic [31:0] PC_F = 32'h1c000100;
  localparam logic [31:0] PC_G = 32'h1c000200;

  branch_resolve_unit_if #(.CNT_W(32)) bus ();

  branch_resolve_unit #(
    .IDX_W(6),
    .TAG_W(8),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one resolved branch for one clock edge; returns just after the
  // edge so the registered outputs reflect this resolve.
  task automatic drive_resolve(input logic [31:0] pc, input logic taken,
                               input logic [31:0] target, input logic pred_taken,
                               input logic [31:0] pred_target);
    @(negedge clk);
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b1;
    bus.ex_pc          = pc;
    bus.ex_taken       = taken;
    bus.ex_target      = target;
    bus.ex_pred_taken  = pred_taken;
    bus.ex_pred_target = pred_target;
    @(posedge clk);
    #1;
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.lk_pc_1 = 32'h1c000000;
    bus.lk_pc_2 = 32'h1c000000;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.lk_taken_1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_lk_taken got=%b exp=0", bus.lk_taken_1); end
    total++; if (bus.lk_target_1 !== 32'h1c000004) begin bad++; $display("[TB] FAIL reset_lk_target got=%h exp=1c000004", bus.lk_target_1); end
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush got=%b exp=0", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_rpc got=%h exp=0", bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 32'h0) begin bad++; $display("[TB] FAIL reset_branch_cnt got=%0d exp=0", bus.branch_cnt); end
    total++; if (bus.mispredict_cnt !== 32'h0) begin bad++; $display("[TB] FAIL reset_mis_cnt got=%0d exp=0", bus.mispredict_cnt); end
    @(negedge clk);
    rst = 1'b0;
    exp_branch = 0;
    exp_mis    = 0;
  endtask

  task automatic test_allocate();
    drive_resolve(PC_A, 1'b1, 32'h1c000100, 1'b0, 32'h0);
    exp_branch++; exp_mis++;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL alloc_flush got=%b exp=1", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("[TB] FAIL alloc_rv got=%b exp=1", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h1c000100) begin bad++; $display("[TB] FAIL alloc_rpc got=%h exp=1c000100", bus.redirect_pc); end
    total++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin bad++; $display("[TB] FAIL alloc_mis_cnt got=%0d exp=%0d", bus.mispredict_cnt, exp_mis); end
    total++; if (bus.branch_cnt !== 32'(exp_branch)) begin bad++; $display("[TB] FAIL alloc_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    bus.lk_pc_2 = PC_A;
    bus.lk_pc_1 = PC_A + 32'd4;
    #1;
    total++; if (bus.lk_taken_2 !== 1'b1) begin bad++; $display("[TB] FAIL alloc_lk_taken got=%b exp=1", bus.lk_taken_2); end
    total++; if (bus.lk_target_2 !== 32'h1c000100) begin bad++; $display("[TB] FAIL alloc_lk_target got=%h exp=1c000100", bus.lk_target_2); end
    total++; if (bus.lk_taken_1 !== 1'b0) begin bad++; $display("[TB] FAIL alloc_miss_taken got=%b exp=0", bus.lk_taken_1); end
    total++; if (bus.lk_target_1 !== 32'h1c000018) begin bad++; $display("[TB] FAIL alloc_miss_target got=%h exp=1c000018", bus.lk_target_1); end
    idle_cycle();
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL alloc_flush_drop got=%b exp=0", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL alloc_rv_drop got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h1c000100) begin bad++; $display("[TB] FAIL alloc_rpc_hold got=%h exp=1c000100", bus.redirect_pc); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      drive_resolve(PC_A, 1'b1, 32'h1c000100, 1'b1, 32'h1c000100);
      exp_branch++;
      total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL sat_no_flush[%0d] got=%b exp=0", i, bus.flush); end
    end
    total++; if (bus.branch_cnt !== 32'(exp_branch)) begin bad++; $display("[TB] FAIL sat_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    drive_resolve(PC_A, 1'b0, 32'h0, 1'b1, 32'h1c000100);
    exp_branch++; exp_mis++;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL sat_nt_flush got=%b exp=1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h1c000014) begin bad++; $display("[TB] FAIL sat_nt_rpc got=%h exp=1c000014", bus.redirect_pc); end
    idle_cycle();
    bus.lk_pc_1 = PC_A;
    #1;
    total++; if (bus.lk_taken_1 !== 1'b1) begin bad++; $display("[TB] FAIL sat_cnt2_taken got=%b exp=1", bus.lk_taken_1); end
    total++; if (bus.lk_target_1 !== 32'h1c000100) begin bad++; $display("[TB] FAIL sat_target_kept got=%h exp=1c000100", bus.lk_target_1); end
    drive_resolve(PC_A, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_branch++;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL sat_nt2_flush got=%b exp=0", bus.flush); end
    total++; if (bus.lk_taken_1 !== 1'b0) begin bad++; $display("[TB] FAIL sat_cnt1_taken got=%b exp=0", bus.lk_taken_1); end
    total++; if (bus.lk_target_1 !== 32'h1c000100) begin bad++; $display("[TB] FAIL sat_cnt1_target got=%h exp=1c000100", bus.lk_target_1); end
    total++; if (bus.branch_cnt !== 32'(exp_branch)) begin bad++; $display("[TB] FAIL sat_branch_cnt2 got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin bad++; $display("[TB] FAIL sat_mis_cnt got=%0d exp=%0d", bus.mispredict_cnt, exp_mis); end
  endtask

  task automatic test_target_mismatch();
    drive_resolve(PC_B, 1'b1, 32'h1c000300, 1'b1, 32'h1c000200);
    exp_branch++; exp_mis++;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL tgt_flush got=%b exp=1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h1c000300) begin bad++; $display("[TB] FAIL tgt_rpc got=%h exp=1c000300", bus.redirect_pc); end
    idle_cycle();
    bus.lk_pc_2 = PC_B;
    #1;
    total++; if (bus.lk_taken_2 !== 1'b1) begin bad++; $display("[TB] FAIL tgt_lk_taken got=%b exp=1", bus.lk_taken_2); end
    total++; if (bus.lk_target_2 !== 32'h1c000300) begin bad++; $display("[TB] FAIL tgt_lk_target got=%h exp=1c000300", bus.lk_target_2); end
  endtask

  task automatic test_non_branch();
    @(negedge clk);
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b0;
    bus.ex_pc          = PC_B;
    bus.ex_taken       = 1'b1;
    bus.ex_target      = 32'h1c000900;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'h0;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL nonbr_flush got=%b exp=0", bus.flush); end
    total++; if (bus.branch_cnt !== 32'(exp_branch)) begin bad++; $display("[TB] FAIL nonbr_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.lk_target_2 !== 32'h1c000300) begin bad++; $display("[TB] FAIL nonbr_target got=%h exp=1c000300", bus.lk_target_2); end
  endtask

  task automatic test_wrong_path();
    drive_resolve(PC_C, 1'b1, 32'h1c000400, 1'b0, 32'h0);
    exp_branch++; exp_mis++;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL wp_first_flush got=%b exp=1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h1c000400) begin bad++; $display("[TB] FAIL wp_first_rpc got=%h exp=1c000400", bus.redirect_pc); end
    drive_resolve(PC_D, 1'b1, 32'h1c000500, 1'b0, 32'h0);
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL wp_second_flush got=%b exp=0", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL wp_second_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h1c000400) begin bad++; $display("[TB] FAIL wp_second_rpc got=%h exp=1c000400", bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 32'(exp_branch)) begin bad++; $display("[TB] FAIL wp_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin bad++; $display("[TB] FAIL wp_mis_cnt got=%0d exp=%0d", bus.mispredict_cnt, exp_mis); end
    bus.lk_pc_1 = PC_D;
    #1;
    total++; if (bus.lk_target_1 !== 32'h1c0000c4) begin bad++; $display("[TB] FAIL wp_no_train got=%h exp=1c0000c4", bus.lk_target_1); end
    drive_resolve(PC_D, 1'b1, 32'h1c000500, 1'b0, 32'h0);
    exp_branch++; exp_mis++;
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL wp_third_flush got=%b exp=1", bus.flush); end
    total++; if (bus.redirect_pc !== 32'h1c000500) begin bad++; $display("[TB] FAIL wp_third_rpc got=%h exp=1c000500", bus.redirect_pc); end
    total++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin bad++; $display("[TB] FAIL wp_third_mis got=%0d exp=%0d", bus.mispredict_cnt, exp_mis); end
    idle_cycle();
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.ex_valid       = 1'b1;
    bus.ex_is_branch   = 1'b1;
    bus.ex_pc          = PC_F;
    bus.ex_taken       = 1'b1;
    bus.ex_target      = 32'h1c000600;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = 32'h0;
    bus.lk_pc_1        = PC_F;
    #1;
    total++; if (bus.lk_taken_1 !== 1'b0) begin bad++; $display("[TB] FAIL same_old_taken got=%b exp=0", bus.lk_taken_1); end
    total++; if (bus.lk_target_1 !== 32'h1c000104) begin bad++; $display("[TB] FAIL same_old_target got=%h exp=1c000104", bus.lk_target_1); end
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    exp_branch++; exp_mis++;
    total++; if (bus.lk_taken_1 !== 1'b1) begin bad++; $display("[TB] FAIL same_new_taken got=%b exp=1", bus.lk_taken_1); end
    total++; if (bus.lk_target_1 !== 32'h1c000600) begin bad++; $display("[TB] FAIL same_new_target got=%h exp=1c000600", bus.lk_target_1); end
    idle_cycle();
  endtask

  task automatic test_collision();
    drive_resolve(PC_G, 1'b1, 32'h1c000700, 1'b1, 32'h1c000700);
    exp_branch++;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL coll_flush got=%b exp=0", bus.flush); end
    bus.lk_pc_1 = PC_F;
    bus.lk_pc_2 = PC_G;
    #1;
    total++; if (bus.lk_target_1 !== 32'h1c000104) begin bad++; $display("[TB] FAIL coll_evicted got=%h exp=1c000104", bus.lk_target_1); end
    total++; if (bus.lk_target_2 !== 32'h1c000700) begin bad++; $display("[TB] FAIL coll_new_target got=%h exp=1c000700", bus.lk_target_2); end
    drive_resolve(PC_G, 1'b0, 32'h0, 1'b0, 32'h0);
    exp_branch++;
    total++; if (bus.lk_taken_2 !== 1'b1) begin bad++; $display("[TB] FAIL coll_retrain got=%b exp=1", bus.lk_taken_2); end
    total++; if (bus.branch_cnt !== 32'(exp_branch)) begin bad++; $display("[TB] FAIL coll_branch_cnt got=%0d exp=%0d", bus.branch_cnt, exp_branch); end
    total++; if (bus.mispredict_cnt !== 32'(exp_mis)) begin bad++; $display("[TB] FAIL coll_mis_cnt got=%0d exp=%0d", bus.mispredict_cnt, exp_mis); end
  endtask

  task automatic test_reset_in_redirect();
    drive_resolve(PC_A, 1'b1, 32'h1c000100, 1'b0, 32'h0);
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL rstr_pre_flush got=%b exp=1", bus.flush); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.lk_pc_1 = PC_A;
    bus.lk_pc_2 = PC_G;
    #1;
    total++; if (bus.flush !== 1'b0) begin bad++; $display("[TB] FAIL rstr_flush got=%b exp=0", bus.flush); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstr_rv got=%b exp=0", bus.redirect_valid); end
    total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL rstr_rpc got=%h exp=0", bus.redirect_pc); end
    total++; if (bus.branch_cnt !== 32'h0) begin bad++; $display("[TB] FAIL rstr_branch_cnt got=%0d exp=0", bus.branch_cnt); end
    total++; if (bus.lk_target_1 !== 32'h1c000014) begin bad++; $display("[TB] FAIL rstr_table_a got=%h exp=1c000014", bus.lk_target_1); end
    total++; if (bus.lk_taken_2 !== 1'b0) begin bad++; $display("[TB] FAIL rstr_table_g got=%b exp=0", bus.lk_taken_2); end
    @(negedge clk);
    rst = 1'b0;
    drive_resolve(PC_B, 1'b1, 32'h1c000300, 1'b0, 32'h0);
    total++; if (bus.flush !== 1'b1) begin bad++; $display("[TB] FAIL rstr_idle_flush got=%b exp=1", bus.flush); end
    total++; if (bus.branch_cnt !== 32'd1) begin bad++; $display("[TB] FAIL rstr_idle_cnt got=%0d exp=1", bus.branch_cnt); end
    idle_cycle();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_branch = 0;
    exp_mis    = 0;
    rst = 1'b1;
    bus.lk_pc_1        = '0;
    bus.lk_pc_2        = '0;
    bus.ex_valid       = 1'b0;
    bus.ex_is_branch   = 1'b0;
    bus.ex_pc          = '0;
    bus.ex_taken       = 1'b0;
    bus.ex_target      = '0;
    bus.ex_pred_taken  = 1'b0;
    bus.ex_pred_target = '0;
    test_reset();
    test_allocate();
    test_saturation();
    test_target_mismatch();
    test_non_branch();
    test_wrong_path();
    test_same_cycle();
    test_collision();
    test_reset_in_redirect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
